// File: rtl/br_issue_queue_pkg.sv
// Shared types and sizing constants for the branch issue queue and its branch FU interface.
package br_issue_queue_pkg;

    localparam int unsigned BR_IQ_DEPTH  = 8;
    localparam int unsigned BR_CDB_WIDTH = 4;
    localparam int unsigned BR_PHY_W     = 6;

    typedef enum logic [3:0] {
        BrOpBeq,
        BrOpBne,
        BrOpBlt,
        BrOpBge,
        BrOpBltu,
        BrOpBgeu,
        BrOpJal,
        BrOpJalr,
        BrOpAuipc
    } br_op_e;

    typedef struct packed {
        br_op_e                op;
        logic [31:0]           pc;
        logic [31:0]           imm;
        logic [BR_PHY_W-1:0]   rd_phy;
        logic [31:0]           rs1_value;
        logic [31:0]           rs2_value;
    } fu_br_reg_t;

    typedef struct packed {
        logic                  valid;
        fu_br_reg_t            payload;
        logic [BR_PHY_W-1:0]   rs1_phy;
        logic [BR_PHY_W-1:0]   rs2_phy;
        logic                  rs1_rdy;
        logic                  rs2_rdy;
    } br_iq_entry_t;

endpackage

// File: rtl/br_iq_wakeup_match.sv
// Compares one physical register index against every CDB wakeup port.
module br_iq_wakeup_match
    import br_issue_queue_pkg::*;
#(
    parameter int unsigned CDB_WIDTH = BR_CDB_WIDTH,
    parameter int unsigned PHY_W     = BR_PHY_W
) (
    input  logic [PHY_W-1:0]           phy,
    input  logic [CDB_WIDTH-1:0]       cdb_valid,
    input  logic [CDB_WIDTH*PHY_W-1:0] cdb_rd_phy,
    output logic                       hit
);

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < CDB_WIDTH; i++) begin
            if (cdb_valid[i] && (cdb_rd_phy[i*PHY_W +: PHY_W] == phy)) begin
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/br_issue_queue.sv
// In-order issue queue for branch-class uops feeding the branch FU.
// Optional perf counters are enabled by defining BR_ISSUE_QUEUE_PERF_EN.
module br_issue_queue
    import br_issue_queue_pkg::*;
#(
    parameter int unsigned DEPTH     = BR_IQ_DEPTH,
    parameter int unsigned CDB_WIDTH = BR_CDB_WIDTH,
    parameter int unsigned PHY_W     = BR_PHY_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       dispatch_valid,
    output logic                       dispatch_ready,
    input  fu_br_reg_t                 dispatch_uop,
    input  logic [PHY_W-1:0]           dispatch_rs1_phy,
    input  logic [PHY_W-1:0]           dispatch_rs2_phy,
    input  logic                       dispatch_rs1_rdy,
    input  logic                       dispatch_rs2_rdy,
    input  logic [CDB_WIDTH-1:0]       cdb_valid,
    input  logic [CDB_WIDTH*PHY_W-1:0] cdb_rd_phy,
    output logic [PHY_W-1:0]           prf_rs1_phy,
    output logic [PHY_W-1:0]           prf_rs2_phy,
    input  logic [31:0]                prf_rs1_value,
    input  logic [31:0]                prf_rs2_value,
    output logic                       br_rs_valid,
    input  logic                       fu_br_ready,
    output fu_br_reg_t                 fu_br_reg_in,
    input  logic                       flush
`ifdef BR_ISSUE_QUEUE_PERF_EN
    ,
    output logic [31:0]                perf_full_stall_cnt,
    output logic [31:0]                perf_operand_stall_cnt
`endif
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    br_iq_entry_t     entries_q [DEPTH];
    br_iq_entry_t     entries_d [DEPTH];
    br_iq_entry_t     head_entry;
    br_iq_entry_t     new_entry;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [IDX_W-1:0] head_idx, tail_idx;
    logic             full;
    logic             head_rdy;
    logic             issue_fire;
    logic             dispatch_fire;
    logic [DEPTH-1:0] rs1_hit, rs2_hit;
    logic             disp_rs1_hit, disp_rs2_hit;

    assign head_idx = head_q[IDX_W-1:0];
    assign tail_idx = tail_q[IDX_W-1:0];
    assign full     = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry_match
        br_iq_wakeup_match #(
            .CDB_WIDTH (CDB_WIDTH),
            .PHY_W     (PHY_W)
        ) u_rs1_match (
            .phy        (entries_q[g].rs1_phy),
            .cdb_valid  (cdb_valid),
            .cdb_rd_phy (cdb_rd_phy),
            .hit        (rs1_hit[g])
        );
        br_iq_wakeup_match #(
            .CDB_WIDTH (CDB_WIDTH),
            .PHY_W     (PHY_W)
        ) u_rs2_match (
            .phy        (entries_q[g].rs2_phy),
            .cdb_valid  (cdb_valid),
            .cdb_rd_phy (cdb_rd_phy),
            .hit        (rs2_hit[g])
        );
    end

    br_iq_wakeup_match #(
        .CDB_WIDTH (CDB_WIDTH),
        .PHY_W     (PHY_W)
    ) u_disp_rs1_match (
        .phy        (dispatch_rs1_phy),
        .cdb_valid  (cdb_valid),
        .cdb_rd_phy (cdb_rd_phy),
        .hit        (disp_rs1_hit)
    );

    br_iq_wakeup_match #(
        .CDB_WIDTH (CDB_WIDTH),
        .PHY_W     (PHY_W)
    ) u_disp_rs2_match (
        .phy        (dispatch_rs2_phy),
        .cdb_valid  (cdb_valid),
        .cdb_rd_phy (cdb_rd_phy),
        .hit        (disp_rs2_hit)
    );

    assign head_entry     = entries_q[head_idx];
    assign head_rdy       = head_entry.valid && head_entry.rs1_rdy && head_entry.rs2_rdy;
    assign br_rs_valid    = head_rdy && !flush;
    assign issue_fire     = br_rs_valid && fu_br_ready;
    assign dispatch_ready = !full;
    assign dispatch_fire  = dispatch_valid && !full && !flush;
    assign prf_rs1_phy    = head_entry.rs1_phy;
    assign prf_rs2_phy    = head_entry.rs2_phy;

    always_comb begin
        fu_br_reg_in           = head_entry.payload;
        fu_br_reg_in.rs1_value = prf_rs1_value;
        fu_br_reg_in.rs2_value = prf_rs2_value;
    end

    // p0 is hardwired zero, and a same-cycle CDB broadcast must not be missed.
    always_comb begin
        new_entry                   = '0;
        new_entry.valid             = 1'b1;
        new_entry.payload           = dispatch_uop;
        new_entry.payload.rs1_value = '0;
        new_entry.payload.rs2_value = '0;
        new_entry.rs1_phy           = dispatch_rs1_phy;
        new_entry.rs2_phy           = dispatch_rs2_phy;
        new_entry.rs1_rdy           = dispatch_rs1_rdy || (dispatch_rs1_phy == '0) || disp_rs1_hit;
        new_entry.rs2_rdy           = dispatch_rs2_rdy || (dispatch_rs2_phy == '0) || disp_rs2_hit;
    end

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i].valid = 1'b0;
            end
            head_d = '0;
            tail_d = '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entries_q[i].valid) begin
                    if (rs1_hit[i]) entries_d[i].rs1_rdy = 1'b1;
                    if (rs2_hit[i]) entries_d[i].rs2_rdy = 1'b1;
                end
            end
            if (issue_fire) begin
                entries_d[head_idx].valid = 1'b0;
                head_d = head_q + PTR_W'(1);
            end
            // Not full, so the tail slot never aliases the issuing head slot.
            if (dispatch_fire) begin
                entries_d[tail_idx] = new_entry;
                tail_d = tail_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            entries_q <= entries_d;
        end
    end

`ifdef BR_ISSUE_QUEUE_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_full_stall_cnt    <= '0;
            perf_operand_stall_cnt <= '0;
        end else begin
            if (dispatch_valid && full && (perf_full_stall_cnt != '1)) begin
                perf_full_stall_cnt <= perf_full_stall_cnt + 32'd1;
            end
            if (head_entry.valid && !(head_entry.rs1_rdy && head_entry.rs2_rdy) &&
                (perf_operand_stall_cnt != '1)) begin
                perf_operand_stall_cnt <= perf_operand_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_br_issue_queue.sv
// Self-checking bench for br_issue_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_br_issue_queue;
    import br_issue_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int CDBW  = 4;
    localparam int PW    = 6;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 dispatch_valid;
    logic                 dispatch_ready;
    fu_br_reg_t           dispatch_uop;
    logic [PW-1:0]        dispatch_rs1_phy, dispatch_rs2_phy;
    logic                 dispatch_rs1_rdy, dispatch_rs2_rdy;
    logic [CDBW-1:0]      cdb_valid;
    logic [CDBW*PW-1:0]   cdb_rd_phy;
    logic [PW-1:0]        prf_rs1_phy, prf_rs2_phy;
    logic [31:0]          prf_rs1_value, prf_rs2_value;
    logic                 br_rs_valid;
    logic                 fu_br_ready;
    fu_br_reg_t           fu_br_reg_in;
    logic                 flush;
`ifdef BR_ISSUE_QUEUE_PERF_EN
    logic [31:0]          perf_full_stall_cnt, perf_operand_stall_cnt;
`endif

    br_issue_queue #(
        .DEPTH     (DEPTH),
        .CDB_WIDTH (CDBW),
        .PHY_W     (PW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .dispatch_valid   (dispatch_valid),
        .dispatch_ready   (dispatch_ready),
        .dispatch_uop     (dispatch_uop),
        .dispatch_rs1_phy (dispatch_rs1_phy),
        .dispatch_rs2_phy (dispatch_rs2_phy),
        .dispatch_rs1_rdy (dispatch_rs1_rdy),
        .dispatch_rs2_rdy (dispatch_rs2_rdy),
        .cdb_valid        (cdb_valid),
        .cdb_rd_phy       (cdb_rd_phy),
        .prf_rs1_phy      (prf_rs1_phy),
        .prf_rs2_phy      (prf_rs2_phy),
        .prf_rs1_value    (prf_rs1_value),
        .prf_rs2_value    (prf_rs2_value),
        .br_rs_valid      (br_rs_valid),
        .fu_br_ready      (fu_br_ready),
        .fu_br_reg_in     (fu_br_reg_in),
        .flush            (flush)
`ifdef BR_ISSUE_QUEUE_PERF_EN
        ,
        .perf_full_stall_cnt    (perf_full_stall_cnt),
        .perf_operand_stall_cnt (perf_operand_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        fu_br_reg_t    uop;
        logic [PW-1:0] p1;
        logic [PW-1:0] p2;
        bit            r1;
        bit            r2;
    } mentry_t;

    mentry_t     mq[$];
    int          n_cmp = 0;
    int          n_mis = 0;
    logic [31:0] m_full_cnt = 0;
    logic [31:0] m_oper_cnt = 0;

    task automatic check_val(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit cdb_hit(input logic [PW-1:0] phy);
        for (int i = 0; i < CDBW; i++) begin
            if (cdb_valid[i] && cdb_rd_phy[i*PW +: PW] == phy) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic fu_br_reg_t make_uop(input br_op_e op);
        fu_br_reg_t u;
        u.op        = op;
        u.pc        = $urandom;
        u.imm       = $urandom;
        u.rd_phy    = PW'($urandom_range(0, 63));
        u.rs1_value = $urandom;
        u.rs2_value = $urandom;
        return u;
    endfunction

    task automatic idle_inputs();
        dispatch_valid   = 1'b0;
        dispatch_uop     = make_uop(BrOpBeq);
        dispatch_rs1_phy = '0;
        dispatch_rs2_phy = '0;
        dispatch_rs1_rdy = 1'b0;
        dispatch_rs2_rdy = 1'b0;
        cdb_valid        = '0;
        cdb_rd_phy       = '0;
        prf_rs1_value    = $urandom;
        prf_rs2_value    = $urandom;
        fu_br_ready      = 1'b0;
        flush            = 1'b0;
    endtask

    task automatic set_dispatch(input br_op_e op, input logic [PW-1:0] p1, input bit r1,
                                input logic [PW-1:0] p2, input bit r2);
        dispatch_valid   = 1'b1;
        dispatch_uop     = make_uop(op);
        dispatch_rs1_phy = p1;
        dispatch_rs1_rdy = r1;
        dispatch_rs2_phy = p2;
        dispatch_rs2_rdy = r2;
    endtask

    // Called with inputs applied just after a falling edge; checks, updates model, advances.
    task automatic step();
        bit         exp_v;
        bit         pre_full;
        fu_br_reg_t exp_uop;
        mentry_t    e;
        #1;
        pre_full = (mq.size() == DEPTH);
        exp_v    = (mq.size() > 0) && mq[0].r1 && mq[0].r2 && !flush;
        check_val("dispatch_ready", 160'(dispatch_ready), 160'(!pre_full));
        check_val("br_rs_valid", 160'(br_rs_valid), 160'(exp_v));
        if (mq.size() > 0) begin
            check_val("prf_rs1_phy", 160'(prf_rs1_phy), 160'(mq[0].p1));
            check_val("prf_rs2_phy", 160'(prf_rs2_phy), 160'(mq[0].p2));
            if (exp_v) begin
                exp_uop           = mq[0].uop;
                exp_uop.rs1_value = prf_rs1_value;
                exp_uop.rs2_value = prf_rs2_value;
                check_val("fu_br_reg_in", 160'(fu_br_reg_in), 160'(exp_uop));
            end
        end
`ifdef BR_ISSUE_QUEUE_PERF_EN
        check_val("perf_full", 160'(perf_full_stall_cnt), 160'(m_full_cnt));
        check_val("perf_oper", 160'(perf_operand_stall_cnt), 160'(m_oper_cnt));
`endif
        if (dispatch_valid && pre_full && m_full_cnt != 32'hffff_ffff) m_full_cnt++;
        if (mq.size() > 0 && !(mq[0].r1 && mq[0].r2) && m_oper_cnt != 32'hffff_ffff)
            m_oper_cnt++;
        if (flush) begin
            mq.delete();
        end else begin
            foreach (mq[i]) begin
                if (cdb_hit(mq[i].p1)) mq[i].r1 = 1'b1;
                if (cdb_hit(mq[i].p2)) mq[i].r2 = 1'b1;
            end
            if (exp_v && fu_br_ready) void'(mq.pop_front());
            if (dispatch_valid && !pre_full) begin
                e.uop = dispatch_uop;
                e.p1  = dispatch_rs1_phy;
                e.p2  = dispatch_rs2_phy;
                e.r1  = dispatch_rs1_rdy || dispatch_rs1_phy == 0 || cdb_hit(dispatch_rs1_phy);
                e.r2  = dispatch_rs2_rdy || dispatch_rs2_phy == 0 || cdb_hit(dispatch_rs2_phy);
                mq.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        #3;
        check_val("reset_br_rs_valid", 160'(br_rs_valid), 160'(0));
        check_val("reset_dispatch_ready", 160'(dispatch_ready), 160'(1));
        @(negedge clk);
        rst = 1'b0;

        // Ready BEQ issues the cycle after dispatch, operands from the PRF.
        idle_inputs();
        fu_br_ready = 1'b1;
        set_dispatch(BrOpBeq, 6'd3, 1'b1, 6'd4, 1'b1);
        step();
        idle_inputs();
        fu_br_ready   = 1'b1;
        prf_rs1_value = 32'h10;
        step();
        idle_inputs();
        step();

        // BNE waits on p5 woken by CDB port 2; younger ready JAL stays behind it.
        idle_inputs();
        fu_br_ready = 1'b1;
        set_dispatch(BrOpBne, 6'd3, 1'b1, 6'd5, 1'b0);
        step();
        idle_inputs();
        fu_br_ready = 1'b1;
        set_dispatch(BrOpJal, 6'd0, 1'b0, 6'd0, 1'b0);
        step();
        idle_inputs();
        fu_br_ready = 1'b1;
        cdb_valid   = 4'b0100;
        cdb_rd_phy[2*PW +: PW] = 6'd5;
        step();
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            fu_br_ready = 1'b1;
            step();
        end

        // Same-cycle CDB bypass at dispatch.
        idle_inputs();
        fu_br_ready = 1'b1;
        set_dispatch(BrOpBlt, 6'd7, 1'b0, 6'd2, 1'b1);
        cdb_valid = 4'b0001;
        cdb_rd_phy[0 +: PW] = 6'd7;
        step();
        idle_inputs();
        fu_br_ready = 1'b1;
        step();

        // Fill, hold a ninth, then drain in order; three rounds wrap the pointers.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < DEPTH + 2; i++) begin
                idle_inputs();
                set_dispatch(br_op_e'($urandom_range(0, 8)), 6'd1, 1'b1, 6'd2, 1'b1);
                step();
            end
            for (int i = 0; i < DEPTH + 2; i++) begin
                idle_inputs();
                fu_br_ready = 1'b1;
                step();
            end
        end

        // Flush with five held and a dispatch pending.
        for (int i = 0; i < 5; i++) begin
            idle_inputs();
            set_dispatch(BrOpBge, 6'd1, 1'b1, 6'd2, 1'b1);
            step();
        end
        idle_inputs();
        set_dispatch(BrOpJalr, 6'd1, 1'b1, 6'd2, 1'b1);
        fu_br_ready = 1'b1;
        flush       = 1'b1;
        step();
        idle_inputs();
        fu_br_ready = 1'b1;
        step();

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            idle_inputs();
            if ($urandom_range(0, 3) != 0) begin
                set_dispatch(br_op_e'($urandom_range(0, 8)),
                             PW'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0),
                             PW'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0));
            end
            cdb_valid = CDBW'($urandom_range(0, 15) & $urandom_range(0, 15));
            for (int p = 0; p < CDBW; p++) cdb_rd_phy[p*PW +: PW] = PW'($urandom_range(0, 7));
            fu_br_ready = ((c / 40) % 3 == 1) ? ($urandom_range(0, 7) == 0)
                                              : ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 63) == 0);
            step();
        end

        // Asynchronous reset between edges with a ready head held.
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            set_dispatch(BrOpBgeu, 6'd0, 1'b0, 6'd0, 1'b0);
            step();
        end
        idle_inputs();
        #1;
        check_val("pre_rst_valid", 160'(br_rs_valid), 160'(1));
        #1;
        rst = 1'b1;
        #1;
        check_val("async_rst_valid", 160'(br_rs_valid), 160'(0));
        check_val("async_rst_ready", 160'(dispatch_ready), 160'(1));
`ifdef BR_ISSUE_QUEUE_PERF_EN
        check_val("async_rst_perf_full", 160'(perf_full_stall_cnt), 160'(0));
        check_val("async_rst_perf_oper", 160'(perf_operand_stall_cnt), 160'(0));
`endif
        mq.delete();
        m_full_cnt = 0;
        m_oper_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            fu_br_ready = 1'b1;
            set_dispatch(BrOpAuipc, 6'd0, 1'b0, 6'd9, 1'b1);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
